// File: rtl/branch_pkg.sv
// Shared definitions for the branch predict unit: branch-type encodings,
// the branch decode helper and the BHT counter reset value.
package branch_pkg;

    typedef enum logic [3:0] {
        BR_BEQ  = 4'b1000,
        BR_BNE  = 4'b1001,
        BR_BLT  = 4'b1100,
        BR_BGE  = 4'b1101,
        BR_BLTU = 4'b1110,
        BR_BGEU = 4'b1111
    } br_op_e;

    // True when the 4-bit ALU control selects a conditional branch
    function automatic logic is_branch(input logic [3:0] op);
        case (op)
            BR_BEQ, BR_BNE, BR_BLT, BR_BGE, BR_BLTU, BR_BGEU: return 1'b1;
            default:                                           return 1'b0;
        endcase
    endfunction

    // Weakly not-taken: all ones below the MSB (01 for a 2-bit counter)
    function automatic int unsigned ctr_reset_value(input int unsigned width);
        return (32'd1 << (width - 1)) - 32'd1;
    endfunction

endpackage

// File: rtl/branch_predict_unit_cmp.sv
// Combinational branch comparator (module branch_cmp): evaluates the branch
// condition selected by aluControl on srcA/srcB.
module branch_cmp
    import branch_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 32
) (
    input  logic [DATA_WIDTH-1:0] srcA,
    input  logic [DATA_WIDTH-1:0] srcB,
    input  logic [3:0]            aluControl,
    output logic                  taken,
    output logic                  branch
);

    // Branch condition evaluation
    always_comb begin
        taken  = 1'b0;
        branch = is_branch(aluControl);
        case (aluControl)
            BR_BEQ:  taken = (srcA == srcB);
            BR_BNE:  taken = (srcA != srcB);
            BR_BLT:  taken = ($signed(srcA) <  $signed(srcB));
            BR_BGE:  taken = ($signed(srcA) >= $signed(srcB));
            BR_BLTU: taken = (srcA <  srcB);
            BR_BGEU: taken = (srcA >= srcB);
            default: taken = 1'b0;
        endcase
    end

endmodule

// File: rtl/branch_predict_unit.sv
// Branch resolution plus bimodal (PC-indexed, untagged) history table.
// Optional statistics counters are enabled with macro BRANCH_STATS_EN.
module branch_predict_unit
    import branch_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned BHT_DEPTH  = 64,
    parameter int unsigned CTR_WIDTH  = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [ADDR_WIDTH-1:0] pc_f,
    output logic                  pred_taken_f,
    input  logic                  ex_valid,
    input  logic                  ex_stall,
    input  logic [ADDR_WIDTH-1:0] ex_pc,
    input  logic [ADDR_WIDTH-1:0] ex_target,
    input  logic                  ex_pred_taken,
    input  logic [DATA_WIDTH-1:0] srcA,
    input  logic [DATA_WIDTH-1:0] srcB,
    input  logic [3:0]            aluControl,
    output logic                  flush,
    output logic [ADDR_WIDTH-1:0] redirect_pc,
    output logic                  branch_taken,
    output logic [31:0]           branch_count,
    output logic [31:0]           mispredict_count
);

    localparam int unsigned IDX_W = $clog2(BHT_DEPTH);
    localparam logic [CTR_WIDTH-1:0] CTR_RST = CTR_WIDTH'(ctr_reset_value(CTR_WIDTH));

    logic [CTR_WIDTH-1:0] bht [BHT_DEPTH];
    logic [IDX_W-1:0]     idx_f;
    logic [IDX_W-1:0]     idx_ex;
    logic                 cmp_taken;
    logic                 cmp_branch;
    logic                 resolve;
    logic                 mispredict;
    logic                 unused_pc_bits;

    branch_cmp #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_cmp (
        .srcA       (srcA),
        .srcB       (srcB),
        .aluControl (aluControl),
        .taken      (cmp_taken),
        .branch     (cmp_branch)
    );

    assign idx_f          = pc_f[IDX_W+1:2];
    assign idx_ex         = ex_pc[IDX_W+1:2];
    assign unused_pc_bits = ^{pc_f[ADDR_WIDTH-1:IDX_W+2], pc_f[1:0]};

    // Fetch prediction reads the table before any same-cycle update lands
    always_comb begin
        pred_taken_f = bht[idx_f][CTR_WIDTH-1];
    end

    // Resolve qualification and mispredict detection
    always_comb begin
        resolve    = ex_valid && !ex_stall && cmp_branch;
        mispredict = resolve && (cmp_taken != ex_pred_taken);
    end

    // BHT saturating-counter update; reset wins over a same-edge resolve
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < BHT_DEPTH; i++) begin
                bht[i] <= CTR_RST;
            end
        end else if (resolve) begin
            if (cmp_taken && (bht[idx_ex] != '1)) begin
                bht[idx_ex] <= bht[idx_ex] + 1'b1;
            end else if (!cmp_taken && (bht[idx_ex] != '0)) begin
                bht[idx_ex] <= bht[idx_ex] - 1'b1;
            end
        end
    end

    // Registered flush, redirect target and resolved outcome
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            flush        <= 1'b0;
            redirect_pc  <= '0;
            branch_taken <= 1'b0;
        end else begin
            flush <= mispredict;
            if (resolve) begin
                branch_taken <= cmp_taken;
                redirect_pc  <= cmp_taken ? ex_target : ex_pc + ADDR_WIDTH'(4);
            end
        end
    end

`ifdef BRANCH_STATS_EN
    // Resolve and mispredict statistics, wrapping at 32 bits
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            branch_count     <= '0;
            mispredict_count <= '0;
        end else begin
            if (resolve)    branch_count     <= branch_count + 32'd1;
            if (mispredict) mispredict_count <= mispredict_count + 32'd1;
        end
    end
`else
    assign branch_count     = '0;
    assign mispredict_count = '0;
`endif

endmodule

// File: tb/tb_branch_predict_unit.sv
// Scoreboard bench for branch_predict_unit: the stimulus process pushes the
// expected registered response for every driven cycle, and a monitor pops and
// compares one entry one time unit after each rising edge.
module tb_branch_predict_unit;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] pc_f;
    logic        pred_taken_f;
    logic        ex_valid;
    logic        ex_stall;
    logic [31:0] ex_pc;
    logic [31:0] ex_target;
    logic        ex_pred_taken;
    logic [31:0] srcA;
    logic [31:0] srcB;
    logic [3:0]  aluControl;
    logic        flush;
    logic [31:0] redirect_pc;
    logic        branch_taken;
    logic [31:0] branch_count;
    logic [31:0] mispredict_count;

    always #5 clk = ~clk;

    branch_predict_unit #(
        .DATA_WIDTH (32),
        .ADDR_WIDTH (32),
        .BHT_DEPTH  (64),
        .CTR_WIDTH  (2)
    ) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .pc_f             (pc_f),
        .pred_taken_f     (pred_taken_f),
        .ex_valid         (ex_valid),
        .ex_stall         (ex_stall),
        .ex_pc            (ex_pc),
        .ex_target        (ex_target),
        .ex_pred_taken    (ex_pred_taken),
        .srcA             (srcA),
        .srcB             (srcB),
        .aluControl       (aluControl),
        .flush            (flush),
        .redirect_pc      (redirect_pc),
        .branch_taken     (branch_taken),
        .branch_count     (branch_count),
        .mispredict_count (mispredict_count)
    );

    typedef struct {
        logic        flush;
        logic [31:0] redirect;
        logic        taken;
        logic        pred;
        logic [31:0] bcnt;
        logic [31:0] mcnt;
    } exp_t;

    exp_t q[$];
    int   n_compared   = 0;
    int   n_mismatched = 0;

    // Reference state
    int          mbht [64];
    logic        m_flush;
    logic [31:0] m_redirect;
    logic        m_taken;
    logic [31:0] m_bcnt;
    logic [31:0] m_mcnt;

    function automatic bit ref_is_branch(input logic [3:0] op);
        return (op == 4'b1000) || (op == 4'b1001) || (op >= 4'b1100);
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_compared++;
        if (act !== exp) begin
            n_mismatched++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // One driven cycle: rst=1 asserts reset; exp_tk is the hand-computed branch outcome
    task automatic step(input bit rst, input bit v, input bit st,
                        input logic [31:0] pc, input logic [31:0] tgt, input bit pp,
                        input logic [31:0] a, input logic [31:0] b, input logic [3:0] op,
                        input bit exp_tk, input logic [31:0] pcf);
        exp_t e;
        @(negedge clk);
        rst_n         = !rst;
        ex_valid      = v;
        ex_stall      = st;
        ex_pc         = pc;
        ex_target     = tgt;
        ex_pred_taken = pp;
        srcA          = a;
        srcB          = b;
        aluControl    = op;
        pc_f          = pcf;
        if (rst) begin
            for (int i = 0; i < 64; i++) mbht[i] = 1;
            m_flush = 0; m_redirect = '0; m_taken = 0; m_bcnt = '0; m_mcnt = '0;
        end else if (v && !st && ref_is_branch(op)) begin
            if (exp_tk && mbht[pc[7:2]] < 3) mbht[pc[7:2]]++;
            if (!exp_tk && mbht[pc[7:2]] > 0) mbht[pc[7:2]]--;
            m_flush    = (exp_tk != pp);
            m_redirect = exp_tk ? tgt : pc + 32'd4;
            m_taken    = exp_tk;
            m_bcnt++;
            if (m_flush) m_mcnt++;
        end else begin
            m_flush = 0;
        end
        e.flush    = m_flush;
        e.redirect = m_redirect;
        e.taken    = m_taken;
        e.pred     = (mbht[pcf[7:2]] >= 2);
`ifdef BRANCH_STATS_EN
        e.bcnt = m_bcnt;
        e.mcnt = m_mcnt;
`else
        e.bcnt = '0;
        e.mcnt = '0;
`endif
        q.push_back(e);
    endtask

    task automatic idle(input logic [31:0] pcf);
        step(0, 0, 0, 32'h0, 32'h0, 0, 32'h0, 32'h0, 4'b0000, 0, pcf);
    endtask

    // Monitor: compare every registered output against the queued expectation
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (q.size() > 0) begin
                e = q.pop_front();
                check("flush",            {31'b0, flush},        {31'b0, e.flush});
                check("redirect_pc",      redirect_pc,           e.redirect);
                check("branch_taken",     {31'b0, branch_taken}, {31'b0, e.taken});
                check("pred_taken_f",     {31'b0, pred_taken_f}, {31'b0, e.pred});
                check("branch_count",     branch_count,          e.bcnt);
                check("mispredict_count", mispredict_count,      e.mcnt);
            end
        end
    end

    // Directed stimulus
    initial begin
        int budget;
        rst_n = 0; ex_valid = 0; ex_stall = 0; ex_pc = '0; ex_target = '0;
        ex_pred_taken = 0; srcA = '0; srcB = '0; aluControl = '0; pc_f = 32'h40;

        // Reset, then first taken beq mispredicts
        step(1, 0, 0, 32'h0, 32'h0, 0, 32'h0, 32'h0, 4'b0000, 0, 32'h40);
        step(1, 0, 0, 32'h0, 32'h0, 0, 32'h0, 32'h0, 4'b0000, 0, 32'h40);
        step(0, 1, 0, 32'h40, 32'h80, 0, 32'd5, 32'd5, 4'b1000, 1, 32'h40);
        // Saturate at 3, then two not-taken bne (back-to-back flush)
        step(0, 1, 0, 32'h40, 32'h80, 1, 32'd5, 32'd5, 4'b1000, 1, 32'h40);
        step(0, 1, 0, 32'h40, 32'h80, 1, 32'd7, 32'd7, 4'b1000, 1, 32'h40);
        step(0, 1, 0, 32'h40, 32'h80, 1, 32'd3, 32'd3, 4'b1001, 0, 32'h40);
        step(0, 1, 0, 32'h40, 32'h80, 1, 32'd3, 32'd3, 4'b1001, 0, 32'h40);
        idle(32'h40);
        // Signed vs unsigned compares
        step(0, 1, 0, 32'h100, 32'h200, 0, 32'hFFFFFFFF, 32'd1, 4'b1100, 1, 32'h100);
        step(0, 1, 0, 32'h104, 32'h300, 0, 32'hFFFFFFFF, 32'd1, 4'b1110, 0, 32'h104);
        step(0, 1, 0, 32'h108, 32'h400, 1, 32'hFFFFFFFF, 32'd1, 4'b1111, 1, 32'h108);
        step(0, 1, 0, 32'h10C, 32'h500, 1, 32'hFFFFFFFF, 32'd1, 4'b1101, 0, 32'h100);
        // Stall, non-branch, invalid: no resolve despite mismatching prediction
        step(0, 1, 1, 32'h40, 32'h80, 0, 32'd1, 32'd1, 4'b1000, 1, 32'h40);
        step(0, 1, 0, 32'h40, 32'h80, 1, 32'd1, 32'd1, 4'b0000, 0, 32'h40);
        step(0, 0, 0, 32'h40, 32'h80, 0, 32'd1, 32'd1, 4'b1000, 1, 32'h40);
        // Redirect wraps past the top of the address space
        step(0, 1, 0, 32'hFFFFFFFC, 32'h10, 1, 32'd1, 32'd1, 4'b1001, 0, 32'hFFFFFFFC);
        // 0x140 aliases onto the 0x40 entry
        step(0, 1, 0, 32'h140, 32'h180, 0, 32'd2, 32'd2, 4'b1000, 1, 32'h40);
        idle(32'h140);
        // Reset with a resolve on the same edge
        step(1, 1, 0, 32'h40, 32'h80, 0, 32'd1, 32'd1, 4'b1000, 1, 32'h40);
        idle(32'h140);
        // Ten branches, three mispredicts (entry for 0x80 starts at 01)
        for (int i = 0; i < 7; i++)
            step(0, 1, 0, 32'h80, 32'hC0, 1, 32'd1, 32'd1, 4'b1000, 1, 32'h80);
        for (int i = 0; i < 3; i++)
            step(0, 1, 0, 32'h80, 32'hC0, 1, 32'd1, 32'd1, 4'b1001, 0, 32'h80);
        idle(32'h80);

        budget = 0;
        while (q.size() > 0 && budget < 10) begin
            @(negedge clk);
            budget++;
        end
        if (q.size() > 0) begin
            n_compared++;
            n_mismatched++;
            $display("FAIL drain: %0d entries left, expected 0", q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule
